// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, idle-high line.
// The asynchronous line is synchronised through two flops. Start bits are
// validated at mid-bit using 16x oversampling, each byte is recovered, framing
// errors are flagged and good bytes are counted modulo 512.
//
// Output protocol: rx_valid and frame_err are single-cycle strobes with no
// back-pressure. rx_data is updated on the same edge that raises rx_valid and
// then holds until the next good byte, so a consumer may sample it in the
// rx_valid cycle or at any later time before the next rx_valid.
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       system_clock,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       clr_count,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [8:0] byte_count,
  output logic [2:0] state_dbg
);

  // Clocks per oversampling tick. OVERSAMPLE must stay at 16, because the
  // mid-bit compare values below (7 and 15) assume a 4-bit tick counter.
  localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            rx_m;
  logic            rx_s;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [3:0]      s_cnt;
  logic [2:0]      b_cnt;
  logic [7:0]      shift;

  // Strobes decoded by the FSM and consumed by the datapath.
  logic            start_det;
  logic            s_clr;
  logic            b_clr;
  logic            shift_en;
  logic            good;
  logic            bad;

  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign tick      = (tick_cnt == TICK_LAST);

  // Two-stage synchroniser. Both stages reset to the idle (high) line level.
  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Tick divider. Restarted on start detection so that ticks line up with the edge.
  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (start_det || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    s_clr      = 1'b0;
    b_clr      = 1'b0;
    shift_en   = 1'b0;
    good       = 1'b0;
    bad        = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          start_det  = 1'b1;
          s_clr      = 1'b1;
        end
      end
      START: begin
        if (tick && (s_cnt == 4'd7)) begin
          if (!rx_s) begin
            state_next = DATA;
            s_clr      = 1'b1;
            b_clr      = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (tick && (s_cnt == 4'd15)) begin
          shift_en = 1'b1;
          if (b_cnt == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (tick && (s_cnt == 4'd15)) begin
          if (rx_s) begin
            good       = 1'b1;
            state_next = IDLE;
          end else begin
            bad        = 1'b1;
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Tick-within-bit counter and data-bit counter. s_cnt wraps from 15 to 0
  // naturally, which spaces successive samples exactly one bit apart.
  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt <= 4'd0;
      b_cnt <= 3'd0;
    end else begin
      if (s_clr) begin
        s_cnt <= 4'd0;
      end else if (tick) begin
        s_cnt <= s_cnt + 4'd1;
      end
      if (b_clr) begin
        b_cnt <= 3'd0;
      end else if (shift_en) begin
        b_cnt <= b_cnt + 3'd1;
      end
    end
  end

  // Right-shifting receive register. The first (LSB) bit ends up in bit 0.
  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      shift <= 8'h00;
    end else if (shift_en) begin
      shift <= {rx_s, shift[7:1]};
    end
  end

  // Result registers: data, strobes and good-byte counter (a clear beats an increment).
  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      byte_count <= 9'd0;
    end else begin
      rx_valid  <= good;
      frame_err <= bad;
      if (good) begin
        rx_data <= shift;
      end
      if (clr_count) begin
        byte_count <= 9'd0;
      end else if (good) begin
        byte_count <= byte_count + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx. The main instance runs at 3 clocks per tick, which
// also exercises the truncating divider (5 MHz / 1.6 MHz). A second instance at
// 1 clock per tick runs the 512-frame counter wrap in parallel.
module tb_uart_rx;

  localparam int CLK_FREQ = 5_000_000;
  localparam int BAUD     = 100_000;
  localparam int D        = 3;            // floor(5e6 / (1e5 * 16))
  localparam int BIT      = 16 * D;       // clocks per bit, main instance
  localparam int W_FREQ   = 1_600_000;
  localparam int W_BIT    = 16;           // clocks per bit, wrap instance
  localparam int T_STOP   = 3 + 152 * D;  // line fall to result pulse, in clocks

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rx, clr_count;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy;
  logic [8:0] byte_count;
  logic [2:0] state_dbg;

  logic       rst_w, rx_w, clr_w;
  logic [7:0] rx_data_w;
  logic       rx_valid_w, frame_err_w, busy_w;
  logic [8:0] byte_count_w;
  logic [2:0] state_dbg_w;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)) u_dut (
    .system_clock(clk), .rst_n(rst_n), .rx(rx), .clr_count(clr_count),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .busy(busy), .byte_count(byte_count), .state_dbg(state_dbg)
  );

  uart_rx #(.CLK_FREQ(W_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)) u_wrap (
    .system_clock(clk), .rst_n(rst_w), .rx(rx_w), .clr_count(clr_w),
    .rx_data(rx_data_w), .rx_valid(rx_valid_w), .frame_err(frame_err_w),
    .busy(busy_w), .byte_count(byte_count_w), .state_dbg(state_dbg_w)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int exp_count = 0;
  int n_valid = 0, n_err = 0, n_valid_w = 0, n_err_w = 0;

  // Monitor: records every result pulse away from the active edge.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      n_valid++;
      got_q.push_back(rx_data);
    end
    if (frame_err === 1'b1) n_err++;
    if (rx_valid_w === 1'b1) n_valid_w++;
    if (frame_err_w === 1'b1) n_err_w++;
  end

  // ---------------- driver tasks ----------------
  task automatic set_line(input bit w, input logic v);
    if (w) rx_w = v;
    else rx = v;
  endtask

  // Sends one frame starting at the current negedge. stop_bits is the number
  // of bit times the stop level is held; the line is left high afterwards.
  task automatic send_frame(input bit w, input logic [7:0] b, input logic stop_lvl,
                            input int stop_bits);
    int bl;
    bl = w ? W_BIT : BIT;
    set_line(w, 1'b0);
    repeat (bl) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_line(w, b[i]);
      repeat (bl) @(negedge clk);
    end
    set_line(w, stop_lvl);
    repeat (bl * stop_bits) @(negedge clk);
    set_line(w, 1'b1);
  endtask

  task automatic pulse_clr();
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    clr_count = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h exp 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b exp 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b exp 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (byte_count !== 9'd0) begin errors++; $display("FAIL reset_byte_count: got %0d exp 0", byte_count); end
  endtask

  task automatic test_single();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    got_q.delete();
    fork
      send_frame(1'b0, 8'h51, 1'b1, 1);
      begin
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_early: got %b exp 0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise: got %b exp 1", busy); end
        repeat (T_STOP - 4) @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early: got %b exp 0", rx_valid); end
        @(negedge clk);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL single_valid_time: got %b exp 1", rx_valid); end
        checks++; if (rx_data !== 8'h51) begin errors++; $display("FAIL single_data: got %h exp 51", rx_data); end
        checks++; if (byte_count !== 9'd1) begin errors++; $display("FAIL single_count: got %0d exp 1", byte_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b exp 0", busy); end
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_valid_width: got %b exp 0", rx_valid); end
      end
    join
    exp_count = 1;
    repeat (BIT) @(negedge clk);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL single_pulses: got %0d exp 1", n_valid - v0); end
    checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL single_frame_err: got %0d exp 0", n_err - e0); end
  endtask

  task automatic test_burst();
    int v0;
    pulse_clr();
    exp_count = 0;
    checks++; if (byte_count !== 9'd0) begin errors++; $display("FAIL burst_pre_clear: got %0d exp 0", byte_count); end
    v0 = n_valid;
    got_q.delete();
    for (int i = 0; i < 32; i++) send_frame(1'b0, 8'h7B, 1'b1, 1);
    exp_count = 32;
    repeat (BIT) @(negedge clk);
    checks++; if (n_valid - v0 !== 32) begin errors++; $display("FAIL burst_pulses: got %0d exp 32", n_valid - v0); end
    checks++; if (byte_count !== 9'(exp_count)) begin errors++; $display("FAIL burst_count: got %0d exp %0d", byte_count, exp_count); end
    checks++; if (rx_data !== 8'h7B) begin errors++; $display("FAIL burst_data: got %h exp 7b", rx_data); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== 8'h7B) begin errors++; $display("FAIL burst_byte%0d: got %h exp 7b", i, got_q[i]); end
    end
    pulse_clr();
    exp_count = 0;
    checks++; if (byte_count !== 9'd0) begin errors++; $display("FAIL burst_clear: got %0d exp 0", byte_count); end
    checks++; if (rx_data !== 8'h7B) begin errors++; $display("FAIL burst_clear_data: got %h exp 7b", rx_data); end
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    fork
      begin
        rx = 1'b0;
        repeat (14) @(negedge clk);
        rx = 1'b1;
      end
      begin
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise: got %b exp 1", busy); end
        repeat (8 * D - 1) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hold: got %b exp 1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall: got %b exp 0", busy); end
      end
    join
    repeat (2 * BIT) @(negedge clk);
    checks++; if ((n_valid - v0) !== 0 || (n_err - e0) !== 0) begin errors++; $display("FAIL glitch_pulses: got valid %0d err %0d exp 0 0", n_valid - v0, n_err - e0); end
    checks++; if (byte_count !== 9'(exp_count)) begin errors++; $display("FAIL glitch_count: got %0d exp %0d", byte_count, exp_count); end
  endtask

  task automatic test_frame_err();
    int v0, e0;
    send_frame(1'b0, 8'hA5, 1'b1, 1);
    exp_count++;
    repeat (BIT) @(negedge clk);
    v0 = n_valid; e0 = n_err;
    fork
      send_frame(1'b0, 8'h3C, 1'b0, 3);
      begin
        repeat (T_STOP) @(negedge clk);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_pulse_time: got %b exp 1", frame_err); end
        @(negedge clk);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_pulse_width: got %b exp 0", frame_err); end
      end
    join
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_break: got %b exp 1", busy); end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_hold: got %b exp 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_fall: got %b exp 0", busy); end
    checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d exp 1", n_err - e0); end
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL ferr_valid: got %0d exp 0", n_valid - v0); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL ferr_data_hold: got %h exp a5", rx_data); end
    checks++; if (byte_count !== 9'(exp_count)) begin errors++; $display("FAIL ferr_byte_count: got %0d exp %0d", byte_count, exp_count); end
    send_frame(1'b0, 8'h11, 1'b1, 1);
    exp_count++;
    repeat (BIT) @(negedge clk);
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ferr_next_data: got %h exp 11", rx_data); end
    checks++; if (byte_count !== 9'(exp_count)) begin errors++; $display("FAIL ferr_next_count: got %0d exp %0d", byte_count, exp_count); end
  endtask

  task automatic test_reset_mid();
    int v0, e0;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (4 * BIT + BIT / 2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b exp 1", busy); end
    v0 = n_valid; e0 = n_err;
    rst_n = 1'b0;
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h exp 00", rx_data); end
    checks++; if (byte_count !== 9'd0) begin errors++; $display("FAIL rstmid_count: got %0d exp 0", byte_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b exp 0", busy); end
    checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_pulses: got %b%b exp 00", rx_valid, frame_err); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    repeat (8 * BIT) @(negedge clk);
    checks++; if ((n_valid - v0) !== 0 || (n_err - e0) !== 0) begin errors++; $display("FAIL rstmid_no_pulse: got valid %0d err %0d exp 0 0", n_valid - v0, n_err - e0); end
    send_frame(1'b0, 8'h00, 1'b1, 1);
    exp_count++;
    repeat (BIT) @(negedge clk);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL rstmid_next_pulse: got %0d exp 1", n_valid - v0); end
    checks++; if (byte_count !== 9'd1) begin errors++; $display("FAIL rstmid_next_count: got %0d exp 1", byte_count); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_next_data: got %h exp 00", rx_data); end
  endtask

  // Random bytes, random idle gaps, occasional bad stop bits.
  task automatic test_random();
    int v0, e0, exp_err;
    logic [7:0] b, last;
    bit ok;
    v0 = n_valid; e0 = n_err; exp_err = 0;
    last = rx_data;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      if (ok) begin
        send_frame(1'b0, b, 1'b1, 1);
        exp_q.push_back(b);
        exp_count = (exp_count + 1) % 512;
        last = b;
        repeat ($urandom_range(0, 2) * BIT) @(negedge clk);
      end else begin
        send_frame(1'b0, b, 1'b0, $urandom_range(1, 2));
        exp_err++;
        repeat ($urandom_range(1, 2) * BIT) @(negedge clk);
      end
    end
    repeat (BIT) @(negedge clk);
    checks++; if (n_valid - v0 !== exp_q.size()) begin errors++; $display("FAIL rand_pulses: got %0d exp %0d", n_valid - v0, exp_q.size()); end
    checks++; if (n_err - e0 !== exp_err) begin errors++; $display("FAIL rand_ferr: got %0d exp %0d", n_err - e0, exp_err); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (rx_data !== last) begin errors++; $display("FAIL rand_data: got %h exp %h", rx_data, last); end
    checks++; if (byte_count !== 9'(exp_count)) begin errors++; $display("FAIL rand_count: got %0d exp %0d", byte_count, exp_count); end
  endtask

  // clr_count asserted in the cycle whose edge also commits a good stop bit.
  task automatic test_collision();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    fork
      send_frame(1'b0, b, 1'b1, 1);
      begin
        repeat (T_STOP - 1) @(negedge clk);
        clr_count = 1'b1;
        @(negedge clk);
        clr_count = 1'b0;
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL coll_valid: got %b exp 1", rx_valid); end
        checks++; if (byte_count !== 9'd0) begin errors++; $display("FAIL coll_count: got %0d exp 0", byte_count); end
        checks++; if (rx_data !== b) begin errors++; $display("FAIL coll_data: got %h exp %h", rx_data, b); end
      end
    join
    exp_count = 0;
  endtask

  // Counter wrap on the fast instance: 511 good bytes, then one more gives 0.
  task automatic test_wrap();
    logic [7:0] b;
    rst_w = 1'b0;
    rx_w = 1'b1;
    clr_w = 1'b0;
    repeat (3) @(negedge clk);
    rst_w = 1'b1;
    @(negedge clk);
    checks++; if (byte_count_w !== 9'd0) begin errors++; $display("FAIL wrap_reset: got %0d exp 0", byte_count_w); end
    b = 8'h00;
    for (int i = 0; i < 511; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(1'b1, b, 1'b1, 1);
    end
    repeat (W_BIT) @(negedge clk);
    checks++; if (byte_count_w !== 9'd511) begin errors++; $display("FAIL wrap_511: got %0d exp 511", byte_count_w); end
    checks++; if (rx_data_w !== b) begin errors++; $display("FAIL wrap_data511: got %h exp %h", rx_data_w, b); end
    b = 8'($urandom_range(0, 255));
    send_frame(1'b1, b, 1'b1, 1);
    repeat (W_BIT) @(negedge clk);
    checks++; if (byte_count_w !== 9'd0) begin errors++; $display("FAIL wrap_zero: got %0d exp 0", byte_count_w); end
    checks++; if (rx_data_w !== b) begin errors++; $display("FAIL wrap_data: got %h exp %h", rx_data_w, b); end
    checks++; if (n_valid_w !== 512 || n_err_w !== 0) begin errors++; $display("FAIL wrap_pulses: got valid %0d err %0d exp 512 0", n_valid_w, n_err_w); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; rx = 1'b1; clr_count = 1'b0;
    rst_w = 1'b0; rx_w = 1'b1; clr_w = 1'b0;
    @(negedge clk);
    fork
      begin
        test_reset();
        test_single();
        test_burst();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_random();
        test_collision();
      end
      test_wrap();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
